vga_scan_ctrl: RTL and testbench

Sequencer for the on-screen clock renderer.
- Generates 640x480@60 VGA timing from the pixel clock: h/v counters, sync pulses, display enable, line and frame strobes.
- Owns the six BCD time digits shown on screen. A new time value from the timekeeping logic is buffered and committed only at the start of vertical blanking, so a frame never shows mixed digits.
- Sits between the timekeeper and the pixel renderer; the renderer consumes pos_x/pos_y/disp_en and the committed digits.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_scan_ctrl_if.sv | 32 +++
 rtl/vga_axis_cnt.sv | 36 +++
 rtl/vga_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the on-screen clock scan sequencer.
// Default 640x480@60 timing, digit field offsets and the time-commit state type.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int CW       = 11;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Digit nibble offsets inside the 24-bit {h1,h0,m1,m0,s1,s0} bus.
  localparam int DIG_W  = 24;
  localparam int OFS_S0 = 0;
  localparam int OFS_S1 = 4;
  localparam int OFS_M0 = 8;
  localparam int OFS_M1 = 12;
  localparam int OFS_H0 = 16;
  localparam int OFS_H1 = 20;

  // First blanking line: the only place new digits are allowed to appear.
  localparam int COMMIT_LINE = V_ACTIVE;

  localparam int BLINK_PERIOD = 30;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pend_state_t;

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Bundle between the timekeeper/renderer side (master) and vga_scan_ctrl (slave).
interface vga_scan_ctrl_if;
  import vga_pkg::*;

  // time_upd is a one-cycle strobe qualifying time_in; there is no back-pressure.
  // time_ack pulses for one cycle when the latest buffered value lands on digits.
  logic [DIG_W-1:0] time_in;
  logic             time_upd;
  logic             time_ack;
  logic [DIG_W-1:0] digits;
  logic             h_sync;
  logic             v_sync;
  logic             disp_en;
  logic [CW-1:0]    pos_x;
  logic [CW-1:0]    pos_y;
  logic             line_start;
  logic             frame_start;
  logic             blink;
  pend_state_t      dbg_state;

  modport master (
    output time_in, time_upd,
    input  time_ack, digits, h_sync, v_sync, disp_en, pos_x, pos_y,
           line_start, frame_start, blink, dbg_state
  );

  modport slave (
    input  time_in, time_upd,
    output time_ack, digits, h_sync, v_sync, disp_en, pos_x, pos_y,
           line_start, frame_start, blink, dbg_state
  );
endinterface

// File: rtl/vga_axis_cnt.sv
// One scan axis: wrapping counter plus active/sync phase decode.
module vga_axis_cnt #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          in_active,
  output logic          in_sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYN_LO  = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYN_HI  = CW'(ACTIVE + FP + SYNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign wrap      = en && (cnt == LAST);
  assign in_active = (cnt < ACT_END);
  assign in_sync   = (cnt >= SYN_LO) && (cnt < SYN_HI);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA timing generator and frame-synchronous digit buffer for the clock renderer.
// Optional colon blink generator enabled by defining VGA_BLINK_EN.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CW       = vga_pkg::CW
) (
  input  logic            clk,
  input  logic            reset,
  vga_scan_ctrl_if.slave  bus
);
  import vga_pkg::*;

  localparam logic [CW-1:0] COMMIT_V = CW'(V_ACTIVE);

  logic [CW-1:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap, h_act, v_act, h_syn, v_syn;
  logic frame_evt_q;

  vga_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)) u_h_axis (
    .clk(clk), .reset(reset), .en(1'b1),
    .cnt(h_cnt), .wrap(h_wrap), .in_active(h_act), .in_sync(h_syn)
  );

  vga_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)) u_v_axis (
    .clk(clk), .reset(reset), .en(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .in_active(v_act), .in_sync(v_syn)
  );

  // High exactly while the counters sit at (0,0); reset parks them there.
  always_ff @(posedge clk) begin
    if (reset) frame_evt_q <= 1'b1;
    else       frame_evt_q <= v_wrap;
  end

  logic          hs_q, vs_q, de_q, ls_q, fs_q;
  logic [CW-1:0] px_q, py_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
      px_q <= '0;
      py_q <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= ~h_syn;
      vs_q <= ~v_syn;
      de_q <= h_act && v_act;
      px_q <= (h_act && v_act) ? h_cnt : '0;
      py_q <= (h_act && v_act) ? v_cnt : '0;
      ls_q <= (h_cnt == '0);
      fs_q <= frame_evt_q;
    end
  end

  pend_state_t      state_q, state_d;
  logic [DIG_W-1:0] pend_q, pend_d;
  logic [DIG_W-1:0] digits_q, digits_d;
  logic             ack_q, ack_d;
  logic             commit;

  assign commit = (h_cnt == '0) && (v_cnt == COMMIT_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      digits_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      digits_q <= digits_d;
      ack_q    <= ack_d;
    end
  end

  // A strobe landing on the commit cycle is fresher than anything pending.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    digits_d = digits_q;
    ack_d    = 1'b0;
    if (commit) begin
      if (bus.time_upd) begin
        digits_d = bus.time_in;
        ack_d    = 1'b1;
      end else if (state_q == ST_PEND) begin
        digits_d = pend_q;
        ack_d    = 1'b1;
      end
      state_d = ST_IDLE;
    end else if (bus.time_upd) begin
      pend_d  = bus.time_in;
      state_d = ST_PEND;
    end
  end

`ifdef VGA_BLINK_EN
  logic [4:0] frm_q;
  logic       blink_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frm_q   <= '0;
      blink_q <= 1'b0;
    end else if (frame_evt_q) begin
      if (frm_q == 5'(BLINK_PERIOD - 1)) begin
        frm_q   <= '0;
        blink_q <= ~blink_q;
      end else begin
        frm_q <= frm_q + 1'b1;
      end
    end
  end

  assign bus.blink = blink_q;
`else
  assign bus.blink = 1'b0;
`endif

  assign bus.h_sync      = hs_q;
  assign bus.v_sync      = vs_q;
  assign bus.disp_en     = de_q;
  assign bus.pos_x       = px_q;
  assign bus.pos_y       = py_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.digits      = digits_q;
  assign bus.time_ack    = ack_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl using reduced timing so many whole frames fit in a short run.
// Reference model derives every output from an absolute pixel index with plain arithmetic.
module tb_vga_scan_ctrl;
  import vga_pkg::*;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int COMMIT_PIX = VA * HT;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_scan_ctrl_if bus();

  vga_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] dig;
    logic ack, hs, vs, de, ls, fs, bl, in_rst;
    int   px, py;
  } exp_t;

  exp_t        rec_q[$];
  logic [23:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int printed = 0;

  // Reference model state, owned by the driver
  int          pix;
  bit          pend;
  logic [23:0] pend_val;
  logic [23:0] dig;
  int          fc;
  int          acks_exp = 0;
  int          timeouts = 0;
  bit          done = 1'b0;

  task automatic step(input logic rst, input logic upd, input logic [23:0] tin);
    exp_t r;
    int h, v;
    reset = rst;
    bus.time_upd = upd;
    bus.time_in = tin;
    r.in_rst = rst;
    r.ack = 1'b0;
    if (rst) begin
      pix = 0; pend = 0; pend_val = '0; dig = '0; fc = 0;
      r.dig = '0; r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0;
      r.px = 0; r.py = 0; r.ls = 1'b0; r.fs = 1'b0; r.bl = 1'b0;
    end else begin
      h = pix % HT;
      v = pix / HT;
      if (pix == COMMIT_PIX) begin
        if (upd) begin
          dig = tin; r.ack = 1'b1;
        end else if (pend) begin
          dig = pend_val; r.ack = 1'b1;
        end
        pend = 0;
      end else if (upd) begin
        pend = 1; pend_val = tin;
      end
      if (r.ack) begin
        exp_q.push_back(dig);
        acks_exp++;
      end
      r.dig = dig;
      r.hs = !(h >= HA + HF && h < HA + HF + HS);
      r.vs = !(v >= VA + VF && v < VA + VF + VS);
      r.de = (h < HA) && (v < VA);
      r.px = r.de ? h : 0;
      r.py = r.de ? v : 0;
      r.ls = (h == 0);
      r.fs = (pix == 0);
      if (r.fs) fc++;
`ifdef VGA_BLINK_EN
      r.bl = ((fc / BLINK_PERIOD) % 2) == 1;
`else
      r.bl = 1'b0;
`endif
      pix = (pix + 1) % FT;
    end
    rec_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (pix != target && n <= FT) begin
      step(1'b0, 1'b0, 24'h0);
      n++;
    end
    if (pix != target) timeouts++;
  endtask

  // Monitor: per-cycle scoreboard, ack scoreboard and first-frame statistics
  exp_t        mr;
  logic [23:0] me;
  int out_idx = 0;
  bit win_done = 1'b0;
  int n_fs = 0, n_ls = 0, n_hs_low = 0, n_vs_low = 0, first_hs = -1;
  int acks_seen = 0;

  task automatic report(input string name, input int act, input int req);
    if (printed < 40)
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    printed++;
  endtask

  always @(negedge clk) begin
    if (rec_q.size() != 0) begin
      mr = rec_q.pop_front();
      checks++;
      if (bus.digits !== mr.dig || bus.time_ack !== mr.ack || bus.h_sync !== mr.hs ||
          bus.v_sync !== mr.vs || bus.disp_en !== mr.de || bus.pos_x !== CW'(mr.px) ||
          bus.pos_y !== CW'(mr.py) || bus.line_start !== mr.ls ||
          bus.frame_start !== mr.fs || bus.blink !== mr.bl) begin
        failures++;
        if (printed < 40)
          $display("FAIL outputs t=%0t actual dig=%h ack=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b bl=%b required dig=%h ack=%b hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b bl=%b",
                   $time, bus.digits, bus.time_ack, bus.h_sync, bus.v_sync, bus.disp_en,
                   bus.pos_x, bus.pos_y, bus.line_start, bus.frame_start, bus.blink,
                   mr.dig, mr.ack, mr.hs, mr.vs, mr.de, mr.px, mr.py, mr.ls, mr.fs, mr.bl);
        printed++;
      end
      if (mr.in_rst) begin
        out_idx = 0;
      end else begin
        if (!win_done) begin
          if (bus.frame_start === 1'b1) n_fs++;
          if (bus.line_start === 1'b1) n_ls++;
          if (bus.h_sync === 1'b0) n_hs_low++;
          if (bus.v_sync === 1'b0) n_vs_low++;
          if (bus.h_sync === 1'b0 && first_hs < 0) first_hs = out_idx;
          if (out_idx == FT - 1) begin
            win_done = 1'b1;
            checks++; if (n_fs != 1) begin failures++; report("frame_start_count", n_fs, 1); end
            checks++; if (n_ls != VT) begin failures++; report("line_start_count", n_ls, VT); end
            checks++; if (n_hs_low != HS * VT) begin failures++; report("h_sync_low_clocks", n_hs_low, HS * VT); end
            checks++; if (n_vs_low != VS * HT) begin failures++; report("v_sync_low_clocks", n_vs_low, VS * HT); end
            checks++; if (first_hs != HA + HF) begin failures++; report("h_sync_first_low", first_hs, HA + HF); end
          end
        end
        out_idx++;
      end
    end
    if (bus.time_ack === 1'b1) begin
      checks++;
      acks_seen++;
      if (exp_q.size() == 0) begin
        failures++;
        report("ack_unexpected", 1, 0);
      end else begin
        me = exp_q.pop_front();
        if (bus.digits !== me) begin
          failures++;
          report("ack_digits", int'(bus.digits), int'(me));
        end
      end
    end
    if (done) begin
      done = 1'b0;
      checks++; if (exp_q.size() != 0) begin failures++; report("ack_queue_drained", exp_q.size(), 0); end
      checks++; if (acks_seen != acks_exp) begin failures++; report("ack_total", acks_seen, acks_exp); end
      checks++; if (rec_q.size() != 0) begin failures++; report("record_queue_drained", rec_q.size(), 0); end
      checks++; if (timeouts != 0) begin failures++; report("run_to_bound", timeouts, 0); end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.time_upd = 1'b0;
    bus.time_in  = '0;
    repeat (3) step(1'b1, 1'b0, 24'h0);

    // Single update mid-frame, committed at the first blanking line
    run_to(4 * HT);
    step(1'b0, 1'b1, 24'h235959);
    run_to(0);

    // Two updates before blanking: last one wins, one ack
    run_to(2 * HT);
    step(1'b0, 1'b1, 24'h120000);
    run_to(6 * HT);
    step(1'b0, 1'b1, 24'h120001);
    run_to(0);

    // Update exactly on the commit cycle, then a quiet frame
    run_to(COMMIT_PIX);
    step(1'b0, 1'b1, 24'h000001);
    run_to(0);
    for (int k = 0; k < FT; k++) step(1'b0, 1'b0, 24'h0);

    // Random updates, some forced onto the commit cycle
    for (int f = 0; f < 35; f++) begin
      for (int k = 0; k < FT; k++) begin
        logic upd;
        upd = ($urandom_range(0, 99) == 0) ||
              (pix == COMMIT_PIX && $urandom_range(0, 3) == 0);
        step(1'b0, upd, 24'($urandom));
      end
    end

    // Reset while a value is pending: no ack, digits cleared
    run_to(3 * HT);
    step(1'b0, 1'b1, 24'h987654);
    run_to(8 * HT);
    step(1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    for (int k = 0; k < 2 * FT; k++) step(1'b0, 1'b0, 24'h0);

    bus.time_upd = 1'b0;
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
